// File: rtl/sm_input_conditioner_pkg.sv
// rtl/sm_input_conditioner_pkg.sv - debounce FSM encodings shared by the input conditioner cells
package sm_input_conditioner_pkg;

  typedef logic [1:0] db_state_t;

  localparam db_state_t SM_DB_OFF      = 2'd0;
  localparam db_state_t SM_DB_WAIT_ON  = 2'd1;
  localparam db_state_t SM_DB_ON       = 2'd2;
  localparam db_state_t SM_DB_WAIT_OFF = 2'd3;

  // Accepted level is high while on, including while a release is still being qualified.
  function automatic logic db_level(input db_state_t st);
    return (st == SM_DB_ON) || (st == SM_DB_WAIT_OFF);
  endfunction

endpackage

// File: rtl/sm_debounce_cell.sv
// rtl/sm_debounce_cell.sv - one-bit synchronizer, debounce FSM and press/release strobes
// Auto-repeat of press strobes is built only with SM_INPUT_AUTOREPEAT_EN defined.
module sm_debounce_cell
  import sm_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic s;

  // Synchronizer resets to the inactive (high) pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  db_state_t        fsm;
  db_state_t        fsm_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_db;
  logic             rel_db;
  logic             press_next;

  always_comb begin
    fsm_nxt  = fsm;
    cnt_nxt  = cnt;
    press_db = 1'b0;
    rel_db   = 1'b0;
    case (fsm)
      SM_DB_OFF: begin
        if (s) begin
          fsm_nxt = SM_DB_WAIT_ON;
          cnt_nxt = CNT_W'(1);
        end
      end
      SM_DB_WAIT_ON: begin
        if (!s) begin
          fsm_nxt = SM_DB_OFF;
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          fsm_nxt  = SM_DB_ON;
          cnt_nxt  = '0;
          press_db = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SM_DB_ON: begin
        if (!s) begin
          fsm_nxt = SM_DB_WAIT_OFF;
          cnt_nxt = CNT_W'(1);
        end
      end
      default: begin
        if (s) begin
          fsm_nxt = SM_DB_ON;
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          fsm_nxt = SM_DB_OFF;
          cnt_nxt = '0;
          rel_db  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

`ifdef SM_INPUT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt;
  logic             rpt_phase;
  logic             rpt_hit;

  // First repeat waits the long delay, later ones use the shorter rate.
  assign rpt_hit = REPEAT_EN && (fsm == SM_DB_ON) && s &&
                   (rpt_phase ? (rpt == RPT_W'(REPEAT_RATE - 1))
                              : (rpt == RPT_W'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt       <= '0;
      rpt_phase <= 1'b0;
    end else if ((fsm != SM_DB_ON) || (fsm_nxt != SM_DB_ON)) begin
      rpt       <= '0;
      rpt_phase <= 1'b0;
    end else if (rpt_hit) begin
      rpt       <= '0;
      rpt_phase <= 1'b1;
    end else begin
      rpt <= rpt + 1'b1;
    end
  end

  assign press_next = press_db | rpt_hit;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = REPEAT_EN ^ (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
  assign press_next = press_db;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm           <= SM_DB_OFF;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      fsm           <= fsm_nxt;
      cnt           <= cnt_nxt;
      press         <= press_next;
      release_pulse <= rel_db;
    end
  end

  assign level = db_level(fsm);

endmodule

// File: rtl/sm_input_conditioner.sv
// rtl/sm_input_conditioner.sv - debounced key/switch levels and strobes for the board control path
// Key auto-repeat is enabled by defining SM_INPUT_AUTOREPEAT_EN.
module sm_input_conditioner
  import sm_input_conditioner_pkg::*;
#(
  parameter int KEY_W           = 4,
  parameter int SW_W            = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_n,
  input  logic [SW_W-1:0]  sw_n,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [SW_W-1:0]  sw_state,
  output logic [SW_W-1:0]  sw_change
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    sm_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (1'b1)
    ) u_cell (
      .clk          (clkIn),
      .rst_n        (rst_n),
      .raw_n        (key_n[i]),
      .level        (key_state[i]),
      .press        (key_press[i]),
      .release_pulse(key_release[i])
    );
  end

  // Switches report any accepted edge on a single change strobe.
  for (genvar j = 0; j < SW_W; j++) begin : g_sw
    logic sw_on;
    logic sw_off;

    sm_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (1'b0)
    ) u_cell (
      .clk          (clkIn),
      .rst_n        (rst_n),
      .raw_n        (sw_n[j]),
      .level        (sw_state[j]),
      .press        (sw_on),
      .release_pulse(sw_off)
    );

    assign sw_change[j] = sw_on | sw_off;
  end

endmodule
